// File: rtl/max7219_chain_rx.sv
// Receiver for a daisy chain of MAX7219-style LED drivers. It oversamples the 3-wire SPI link
// on sysclk, collects one 16-bit word per device, and commits all words when chip select rises.
module max7219_chain_rx #(
  parameter int N_DEV       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     spi_clk,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  input  logic [$clog2(N_DEV)-1:0] rd_dev,
  input  logic [3:0]               rd_reg,
  output logic [7:0]               rd_data,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int DEV_W   = $clog2(N_DEV);
  localparam int FRAME_W = 16 * N_DEV;
  localparam int CNT_MAX = FRAME_W + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic                   err_d;
  logic                   frame_done_q, frame_err_q, busy_q;

  logic [7:0]             digit_q     [N_DEV][8];
  logic [7:0]             decode_q    [N_DEV];
  logic [3:0]             intensity_q [N_DEV];
  logic [2:0]             scan_q      [N_DEV];
  logic                   shutdn_q    [N_DEV];
  logic                   test_q      [N_DEV];

  logic [15:0]            word        [N_DEV];
  logic                   unused_nib;
  logic                   dev_ok;
  logic [7:0]             rd_mux;
  logic [7:0]             rd_data_q;

  // All three inputs share one synchronizer depth so their edges stay aligned.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        // A chip-select release beats a coincident clock edge; that bit is dropped.
        if (cs_rise) begin
          if (cnt_q == CNT_W'(FRAME_W)) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (sclk_rise && !cs_s) begin
          shift_d = {shift_q[FRAME_W-2:0], mosi_s};
          if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      frame_done_q <= (state_d == COMMIT);
      frame_err_q  <= err_d;
      busy_q       <= (state_d == SHIFT);
    end
  end

  // Device 0 sits nearest the controller, so it holds the last word shifted in.
  always_comb begin
    unused_nib = 1'b0;
    for (int k = 0; k < N_DEV; k++) begin
      word[k]    = shift_q[16*k +: 16];
      unused_nib = unused_nib ^ (^word[k][15:12]);
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_DEV; k++) begin
        for (int r = 0; r < 8; r++) digit_q[k][r] <= '0;
        decode_q[k]    <= '0;
        intensity_q[k] <= '0;
        scan_q[k]      <= '0;
        shutdn_q[k]    <= 1'b0;
        test_q[k]      <= 1'b0;
      end
    end else if (state_q == COMMIT) begin
      for (int k = 0; k < N_DEV; k++) begin
        case (word[k][11:8])
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit_q[k][word[k][10:8] - 3'd1] <= word[k][7:0];
          4'h9:    decode_q[k]    <= word[k][7:0];
          4'hA:    intensity_q[k] <= word[k][3:0];
          4'hB:    scan_q[k]      <= word[k][2:0];
          4'hC:    shutdn_q[k]    <= word[k][0];
          4'hF:    test_q[k]      <= word[k][0];
          default: ;
        endcase
      end
    end
  end

  if (N_DEV == (1 << DEV_W)) begin : g_dev_full
    assign dev_ok = 1'b1;
  end else begin : g_dev_part
    assign dev_ok = ({{(32-DEV_W){1'b0}}, rd_dev} < 32'(N_DEV));
  end

  always_comb begin
    rd_mux = '0;
    if (dev_ok) begin
      case (rd_reg)
        4'h1, 4'h2, 4'h3, 4'h4,
        4'h5, 4'h6, 4'h7, 4'h8: rd_mux = digit_q[rd_dev][rd_reg[2:0] - 3'd1];
        4'h9:    rd_mux = decode_q[rd_dev];
        4'hA:    rd_mux = {4'h0, intensity_q[rd_dev]};
        4'hB:    rd_mux = {5'h00, scan_q[rd_dev]};
        4'hC:    rd_mux = {7'h00, shutdn_q[rd_dev]};
        4'hF:    rd_mux = {7'h00, test_q[rd_dev]};
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_mux;
  end

  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_max7219_chain_rx.sv
// Directed bench for max7219_chain_rx: drives SPI frames and checks the register file through readback.
module tb_max7219_chain_rx;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       spi_clk, spi_cs_n, spi_mosi;
  logic [1:0] rd_dev;
  logic [3:0] rd_reg;
  logic [7:0] rd_data;
  logic       frame_done, frame_err, busy;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int d0, e0;
  logic [63:0] v64;

  max7219_chain_rx #(.N_DEV(4), .SYNC_STAGES(2)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .rd_dev     (rd_dev),
    .rd_reg     (rd_reg),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if (frame_err === 1'b1)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    tick(4);
    spi_clk = 1'b1;
    tick(4);
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic frame(input logic [127:0] v, input int n);
    spi_cs_n = 1'b0;
    tick(6);
    send_bits(v, n);
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
  endtask

  task automatic rd(input int d, input int r, input logic [7:0] exp);
    rd_dev = d[1:0];
    rd_reg = r[3:0];
    tick(1);
    chk($sformatf("rd_d%0d_r%0h", d, r), {24'h0, rd_data}, {24'h0, exp});
  endtask

  initial begin
    reset    = 1'b1;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rd_dev   = '0;
    rd_reg   = '0;
    tick(3);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd_data, 0);
    reset = 1'b0;
    tick(3);
    for (int d = 0; d < 4; d++)
      for (int r = 1; r < 16; r++) rd(d, r, 8'h00);

    // first frame: words land in reverse device order
    d0 = done_cnt; e0 = err_cnt;
    spi_cs_n = 1'b0;
    tick(6);
    chk("busy_shift", busy, 1);
    send_bits(64'h0155_02AA_0333_0481, 64);
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
    chk("f1_done", done_cnt - d0, 1);
    chk("f1_err", err_cnt - e0, 0);
    chk("f1_busy_end", busy, 0);
    rd(3, 1, 8'h55); rd(2, 2, 8'hAA); rd(1, 3, 8'h33); rd(0, 4, 8'h81);
    rd(0, 1, 8'h00); rd(3, 4, 8'h00);

    frame({4{16'h0AFF}}, 64);
    frame({4{16'h0C03}}, 64);
    frame({4{16'h0BFE}}, 64);
    for (int d = 0; d < 4; d++) begin
      rd(d, 10, 8'h0F); rd(d, 12, 8'h01); rd(d, 11, 8'h06);
    end
    d0 = done_cnt;
    frame({4{16'h00FF}}, 64);
    chk("noop_done", done_cnt - d0, 1);
    for (int d = 0; d < 4; d++) begin
      rd(d, 10, 8'h0F); rd(d, 12, 8'h01); rd(d, 11, 8'h06);
    end
    rd(3, 1, 8'h55);

    frame(64'h09AB_0F01_0877_01C3, 64);
    rd(3, 9, 8'hAB); rd(2, 15, 8'h01); rd(1, 8, 8'h77); rd(0, 1, 8'hC3); rd(1, 3, 8'h33);
    frame(64'h0DFF_0EFF_0AF7_0B0F, 64);
    rd(3, 13, 8'h00); rd(2, 14, 8'h00); rd(1, 10, 8'h07); rd(0, 11, 8'h07); rd(2, 10, 8'h0F);

    // wrong bit counts are discarded
    d0 = done_cnt; e0 = err_cnt;
    frame({4{16'h0A01}}, 63);
    chk("f63_err", err_cnt - e0, 1);
    chk("f63_done", done_cnt - d0, 0);
    frame({5{16'h0A01}}, 65);
    chk("f65_err", err_cnt - e0, 2);
    chk("f65_done", done_cnt - d0, 0);
    rd(1, 10, 8'h07); rd(0, 10, 8'h0F); rd(3, 10, 8'h0F);

    // reset in the middle of a frame with chip select held low
    d0 = done_cnt; e0 = err_cnt;
    spi_cs_n = 1'b0;
    tick(6);
    send_bits(20'hABCDE, 20);
    reset = 1'b1;
    tick(2);
    chk("midrst_busy", busy, 0);
    reset = 1'b0;
    tick(6);
    chk("midrst_rebusy", busy, 1);
    send_bits(44'h0A0_F0AF_F0AF, 44);
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
    chk("midrst_err", err_cnt - e0, 1);
    chk("midrst_done", done_cnt - d0, 0);
    rd(3, 1, 8'h00); rd(0, 4, 8'h00); rd(0, 10, 8'h00); rd(2, 12, 8'h00); rd(1, 3, 8'h00);
    frame(64'h0C01_0102_0203_0304, 64);
    chk("postrst_done", done_cnt - d0, 1);
    rd(3, 12, 8'h01); rd(2, 1, 8'h02); rd(1, 2, 8'h03); rd(0, 3, 8'h04);

    // chip select rises together with the 64th clock edge
    d0 = done_cnt; e0 = err_cnt;
    v64 = 64'h0A05_0A05_0A05_0A05;
    spi_cs_n = 1'b0;
    tick(6);
    send_bits({65'h0, v64[63:1]}, 63);
    spi_mosi = v64[0];
    tick(4);
    spi_clk  = 1'b1;
    spi_cs_n = 1'b1;
    tick(4);
    spi_clk = 1'b0;
    tick(10);
    chk("tie_err", err_cnt - e0, 1);
    chk("tie_done", done_cnt - d0, 0);
    rd(0, 10, 8'h00); rd(3, 10, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
